mbist_march_ctrl: RTL and testbench

MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

---
 rtl/mbist_march_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// ---------------------------------------------------------------------------
// mbist_march_ctrl
//
// Memory BIST controller running the March C- algorithm over a memory of
// N = 2^ADDR_W words. Addresses come from an external up/down counter, which
// this block drives through a load/direction/enable interface.
//
// Element sequence (0 = all-zeros word, 1 = all-ones word):
//   M0 up   w0
//   M1 up   r0,w1
//   M2 up   r1,w0
//   M3 down r0,w1
//   M4 down r1,w0
//   M5 down r0
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   start      : test request, only sampled while idle
//   addr_q     : current address from the external counter
//   cnt_d_in   : counter load value
//   cnt_ld     : counter load
//   cnt_u_d    : counter direction, 1 = up, 0 = down
//   cnt_cen    : counter enable
//   mem_addr   : memory address (follows addr_q combinationally)
//   mem_we     : memory write strobe
//   mem_re     : memory read strobe (data returns the following cycle)
//   mem_wdata  : memory write data
//   mem_rdata  : memory read data
//   busy       : high in every state except IDLE
//   done       : one-cycle completion pulse
//   fail       : sticky mismatch flag, cleared by the next accepted start
//   fail_addr  : address of the first mismatch
//   fail_elem  : element index of the first mismatch
// ---------------------------------------------------------------------------
module mbist_march_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_q,
  output logic [ADDR_W-1:0] cnt_d_in,
  output logic              cnt_ld,
  output logic              cnt_u_d,
  output logic              cnt_cen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    OP_A     = 3'd2,
    OP_B     = 3'd3,
    ELEM_END = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [2:0] LAST_ELEM = 3'd5;

  state_t             state;
  logic [2:0]         elem;

  logic               elem_up;
  logic [2:0]         next_elem;
  logic               next_up;
  logic               at_last;
  logic [DATA_W-1:0]  exp_val;
  logic [DATA_W-1:0]  wr_val;
  logic               mismatch;

  // The memory address is simply the counter output.
  assign mem_addr = addr_q;

  // Per-element attributes decoded from the element index. M0-M2 walk up,
  // M3-M5 walk down. Reads expect ones only in M2 and M4; writes store ones
  // only in M1 and M3. "Last address" is judged from addr_q itself so the
  // counter's carry output is never needed.
  always_comb begin
    elem_up   = (elem < 3'd3);
    next_elem = elem + 3'd1;
    next_up   = (next_elem < 3'd3);
    exp_val   = ((elem == 3'd2) || (elem == 3'd4)) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    wr_val    = ((elem == 3'd1) || (elem == 3'd3)) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    at_last   = elem_up ? (addr_q == {ADDR_W{1'b1}}) : (addr_q == {ADDR_W{1'b0}});
    mismatch  = (state == OP_B) && (mem_rdata != exp_val);
  end

  // Strobes that depend on the live address or the read data of this very
  // cycle. A mismatch in OP_B must kill both the write and the counter step
  // in the same cycle, which is why these cannot be registered.
  always_comb begin
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    cnt_cen = 1'b0;
    unique case (state)
      LOAD: begin
        cnt_cen = 1'b1;
      end
      OP_A: begin
        if (elem == 3'd0) begin
          mem_we  = 1'b1;
          cnt_cen = !at_last;
        end else begin
          mem_re  = 1'b1;
        end
      end
      OP_B: begin
        if (!mismatch) begin
          mem_we  = (elem != LAST_ELEM);
          cnt_cen = !at_last;
        end
      end
      default: begin
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        cnt_cen = 1'b0;
      end
    endcase
  end

  // Main sequencer. State and all outputs that can be known one cycle ahead
  // (busy, done, counter load controls, write data, fail capture) are
  // registered here as a function of the transition being taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      elem      <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt_ld    <= 1'b0;
      cnt_d_in  <= '0;
      cnt_u_d   <= 1'b1;
      mem_wdata <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= 3'd0;
    end else begin
      done   <= 1'b0;
      cnt_ld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            elem      <= 3'd0;
            busy      <= 1'b1;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= 3'd0;
            cnt_ld    <= 1'b1;
            cnt_d_in  <= '0;
            cnt_u_d   <= 1'b1;
          end
        end

        LOAD: begin
          state     <= OP_A;
          mem_wdata <= '0;
        end

        // M0 writes zeros and stays here until the last address; every other
        // element issues its read here and completes the access in OP_B.
        OP_A: begin
          if (elem == 3'd0) begin
            if (at_last) begin
              state <= ELEM_END;
            end
          end else begin
            state     <= OP_B;
            mem_wdata <= wr_val;
          end
        end

        // A mismatch aborts the whole test straight to DONE, recording where
        // and in which element the first failure was seen.
        OP_B: begin
          if (mismatch) begin
            fail      <= 1'b1;
            fail_addr <= addr_q;
            fail_elem <= elem;
            state     <= DONE;
            done      <= 1'b1;
          end else if (at_last) begin
            state <= ELEM_END;
          end else begin
            state     <= OP_A;
            mem_wdata <= '0;
          end
        end

        // Direction and load value for the next element are prepared here so
        // they are already stable during its LOAD cycle.
        ELEM_END: begin
          if (elem == LAST_ELEM) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            elem     <= next_elem;
            state    <= LOAD;
            cnt_ld   <= 1'b1;
            cnt_d_in <= next_up ? {ADDR_W{1'b0}} : {ADDR_W{1'b1}};
            cnt_u_d  <= next_up;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mbist_march_ctrl
//
// Bench for mbist_march_ctrl with ADDR_W=2 (N=4). Includes a behavioural
// up/down counter and a 4-word memory with an optional bit0 stuck-at-1 fault
// at address 2. When a run is launched, the expected per-cycle beat sequence
// of March C- is pushed to a queue; a negedge monitor pops one beat per cycle
// and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_mbist_march_ctrl;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 8;
  localparam int N      = 4;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              ld;
    logic              cen;
    logic              ud;
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] dld;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] addr_q = '0;
  logic [ADDR_W-1:0] cnt_d_in;
  logic              cnt_ld;
  logic              cnt_u_d;
  logic              cnt_cen;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;

  logic [DATA_W-1:0] mem [0:N-1];
  logic              stuck = 1'b0;

  beat_t             sbq[$];
  int                beat_idx = 0;
  int                errors = 0;
  int                checks = 0;

  mbist_march_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .addr_q    (addr_q),
    .cnt_d_in  (cnt_d_in),
    .cnt_ld    (cnt_ld),
    .cnt_u_d   (cnt_u_d),
    .cnt_cen   (cnt_cen),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem)
  );

  always #5 clk = ~clk;

  // External address counter.
  always @(posedge clk) begin
    if (cnt_cen) begin
      if (cnt_ld)       addr_q <= cnt_d_in;
      else if (cnt_u_d) addr_q <= addr_q + 1'b1;
      else              addr_q <= addr_q - 1'b1;
    end
  end

  // Synchronous memory; read data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr] | ((stuck && mem_addr == 2'd2) ? 8'h01 : 8'h00);
  end

  initial begin
    for (int i = 0; i < N; i++) mem[i] = '0;
  end

  // Scoreboard monitor: one expected beat per cycle while the queue is full.
  always @(negedge clk) begin
    beat_t exp_b;
    beat_t obs_b;
    if (sbq.size() > 0) begin
      exp_b       = sbq.pop_front();
      obs_b       = '0;
      obs_b.busy  = busy;
      obs_b.done  = done;
      obs_b.ld    = cnt_ld;
      obs_b.cen   = cnt_cen;
      obs_b.ud    = exp_b.cen ? cnt_u_d : 1'b0;
      obs_b.we    = mem_we;
      obs_b.re    = mem_re;
      obs_b.addr  = (exp_b.we || exp_b.re) ? mem_addr : '0;
      obs_b.wdata = exp_b.we ? mem_wdata : '0;
      obs_b.dld   = exp_b.ld ? cnt_d_in : '0;
      checks++;
      if (obs_b !== exp_b) begin
        errors++;
        $display("[TB] FAIL beat%0d actual=%h required=%h", beat_idx, obs_b, exp_b);
      end
      beat_idx++;
    end
  end

  function automatic beat_t mk(input logic bsy, input logic dn, input logic ld,
                               input logic cen, input logic ud, input logic we,
                               input logic re, input int a, input logic [DATA_W-1:0] wd,
                               input int dl);
    beat_t b;
    b       = '0;
    b.busy  = bsy;
    b.done  = dn;
    b.ld    = ld;
    b.cen   = cen;
    b.ud    = cen ? ud : 1'b0;
    b.we    = we;
    b.re    = re;
    b.addr  = (we || re) ? ADDR_W'(a) : '0;
    b.wdata = we ? wd : '0;
    b.dld   = ld ? ADDR_W'(dl) : '0;
    return b;
  endfunction

  // Expected March C- beats from the cycle after start acceptance through the
  // first IDLE cycle. abort_e/abort_k name the read that is expected to
  // mismatch (-1 for a fault-free run).
  task automatic gen_trace(input int abort_e, input int abort_k);
    logic              up;
    logic              last;
    logic [DATA_W-1:0] wv;
    int                a;
    for (int e = 0; e < 6; e++) begin
      up = (e < 3);
      wv = (e == 1 || e == 3) ? 8'hFF : 8'h00;
      sbq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, up, 1'b0, 1'b0, 0, 8'h00, up ? 0 : N - 1));
      for (int k = 0; k < N; k++) begin
        a    = up ? k : N - 1 - k;
        last = (k == N - 1);
        if (e == 0) begin
          sbq.push_back(mk(1'b1, 1'b0, 1'b0, !last, up, 1'b1, 1'b0, a, 8'h00, 0));
        end else begin
          sbq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a, 8'h00, 0));
          if (e == abort_e && k == abort_k) begin
            sbq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 0));
            sbq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 0));
            sbq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 0));
            return;
          end
          sbq.push_back(mk(1'b1, 1'b0, 1'b0, !last, up, (e != 5), 1'b0, a, wv, 0));
        end
      end
      sbq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 0));
    end
    sbq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 0));
    sbq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 0));
  endtask

  // Pulse start for one cycle and queue the beats expected from then on.
  task automatic launch(input int abort_e, input int abort_k);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    gen_trace(abort_e, abort_k);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, fail, mem_we, mem_re, cnt_ld, cnt_cen} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags actual=%b required=0000000",
               {busy, done, fail, mem_we, mem_re, cnt_ld, cnt_cen});
    end
    checks++;
    if ({fail_addr, fail_elem, mem_wdata, cnt_d_in} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values actual=%h required=0",
               {fail_addr, fail_elem, mem_wdata, cnt_d_in});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_start busy actual=%b required=0", busy);
    end
  endtask

  task automatic test_clean_run;
    int dones;
    int fails;
    dones = 0;
    fails = 0;
    launch(-1, -1);
    for (int i = 1; i <= 58; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (fail) fails++;
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("[TB] FAIL clean_done_count actual=%0d required=1", dones);
    end
    checks++;
    if (fails !== 0) begin
      errors++;
      $display("[TB] FAIL clean_fail_cycles actual=%0d required=0", fails);
    end
  endtask

  task automatic test_fault;
    stuck = 1'b1;
    launch(1, 2);
    repeat (14) @(negedge clk);
    checks++;
    if ({fail, fail_addr, fail_elem} !== {1'b1, 2'd2, 3'd1}) begin
      errors++;
      $display("[TB] FAIL fault_capture actual=%b/%0d/%0d required=1/2/1",
               fail, fail_addr, fail_elem);
    end
    checks++;
    if (mem[2] !== 8'h00) begin
      errors++;
      $display("[TB] FAIL fault_write_suppressed mem2 actual=%h required=00", mem[2]);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({fail, fail_addr, fail_elem, busy} !== {1'b1, 2'd2, 3'd1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL fault_hold actual=%b/%0d/%0d busy=%b required=1/2/1 busy=0",
               fail, fail_addr, fail_elem, busy);
    end
    stuck = 1'b0;
  endtask

  task automatic test_start_ignored;
    int dones;
    dones = 0;
    launch(-1, -1);
    @(negedge clk);
    if (done) dones++;
    checks++;
    if (fail !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fail_cleared_on_start actual=%b required=0", fail);
    end
    for (int i = 2; i <= 58; i++) begin
      @(posedge clk); #1 start = (i < 50) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("[TB] FAIL start_spam_done_count actual=%0d required=1", dones);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_spam_no_restart busy actual=%b required=0", busy);
    end
  endtask

  task automatic test_reset_midrun;
    launch(-1, -1);
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    sbq.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, mem_we, mem_re, done, cnt_cen} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL midrun_reset busy/we/re/done/cen actual=%b required=00000",
               {busy, mem_we, mem_re, done, cnt_cen});
    end
    launch(-1, -1);
    repeat (58) @(negedge clk);
    checks++;
    if (fail !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_run fail actual=%b required=0", fail);
    end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_fault();
    test_start_ignored();
    test_reset_midrun();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
